// File: rtl/benes_cfg_loader.sv
// Double-buffered switch-setting loader for an N-input Benes network: beats fill a shadow
// bank one stage at a time; a commit copies it to the active bank that drives the switches.
module benes_cfg_loader #(
    parameter int unsigned N            = 8,
    parameter int unsigned LOG_N        = $clog2(N),
    parameter int unsigned STAGES       = 2 * LOG_N - 1,
    parameter int unsigned SW_PER_STAGE = N / 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_cfg_valid,
    input  logic [SW_PER_STAGE-1:0]          i_cfg_data,
    output logic                             o_cfg_ready,
    input  logic                             i_commit,
    input  logic                             i_abort,
    output logic                             o_shadow_full,
    output logic                             o_commit_ack,
    output logic                             o_cfg_err,
    output logic [$clog2(STAGES)-1:0]        o_stage_idx,
    output logic [STAGES*SW_PER_STAGE-1:0]   o_switch_set
);

    localparam int unsigned IDX_W  = $clog2(STAGES);
    localparam int unsigned BANK_W = STAGES * SW_PER_STAGE;
    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(STAGES - 1);

    typedef enum logic [0:0] {StLoad, StFull} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BANK_W-1:0]   shadow_q, shadow_d;
    logic [BANK_W-1:0]   active_q, active_d;
    logic                ready_q, ready_d;
    logic                full_q, full_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            full_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            full_q   <= full_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        // Abort dominates: it drops any concurrent beat and suppresses commit and error.
        if (i_abort) begin
            state_d = StLoad;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (i_commit) begin
                        err_d = 1'b1;
                    end
                    // ready_q is low only in the first cycle after reset release.
                    if (ready_q && i_cfg_valid) begin
                        for (int k = 0; k < int'(STAGES); k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                shadow_d[k*SW_PER_STAGE +: SW_PER_STAGE] = i_cfg_data;
                            end
                        end
                        if (idx_q == LAST_STAGE) begin
                            idx_d   = '0;
                            state_d = StFull;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                StFull: begin
                    if (i_commit) begin
                        active_d = shadow_q;
                        ack_d    = 1'b1;
                        state_d  = StLoad;
                    end
                end
                default: begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            endcase
        end

        ready_d = (state_d == StLoad);
        full_d  = (state_d == StFull);
    end

    assign o_cfg_ready   = ready_q;
    assign o_shadow_full = full_q;
    assign o_commit_ack  = ack_q;
    assign o_cfg_err     = err_q;
    assign o_stage_idx   = idx_q;
    assign o_switch_set  = active_q;

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Directed bench for benes_cfg_loader with N=8 (5 stages of 4 switches).
module tb_benes_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic        i_cfg_valid;
    logic [3:0]  i_cfg_data;
    logic        o_cfg_ready;
    logic        i_commit;
    logic        i_abort;
    logic        o_shadow_full;
    logic        o_commit_ack;
    logic        o_cfg_err;
    logic [2:0]  o_stage_idx;
    logic [19:0] o_switch_set;

    int errors = 0;
    int checks = 0;

    benes_cfg_loader #(.N(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_data   (i_cfg_data),
        .o_cfg_ready  (o_cfg_ready),
        .i_commit     (i_commit),
        .i_abort      (i_abort),
        .o_shadow_full(o_shadow_full),
        .o_commit_ack (o_commit_ack),
        .o_cfg_err    (o_cfg_err),
        .o_stage_idx  (o_stage_idx),
        .o_switch_set (o_switch_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [3:0] d);
        i_cfg_valid = 1'b1;
        i_cfg_data  = d;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic commit_pulse();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        i_cfg_valid = 1'b0;
        i_cfg_data  = 4'h0;
        i_commit    = 1'b0;
        i_abort     = 1'b0;

        // Reset
        tick(); tick(); tick();
        chk("rst_switch_set", 32'(o_switch_set), 32'h0);
        chk("rst_ready", 32'(o_cfg_ready), 32'h0);
        chk("rst_full", 32'(o_shadow_full), 32'h0);
        chk("rst_idx", 32'(o_stage_idx), 32'h0);
        chk("rst_ack_err", 32'({o_commit_ack, o_cfg_err}), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", 32'(o_cfg_ready), 32'h1);

        // Basic load and commit
        send_beat(4'h1); send_beat(4'h2);
        chk("idx_after_2", 32'(o_stage_idx), 32'h2);
        send_beat(4'h3); send_beat(4'h4); send_beat(4'h5);
        chk("full_after_5", 32'(o_shadow_full), 32'h1);
        chk("ready_in_full", 32'(o_cfg_ready), 32'h0);
        chk("idx_wrap", 32'(o_stage_idx), 32'h0);
        chk("switch_before_commit", 32'(o_switch_set), 32'h0);
        commit_pulse();
        chk("ack_pulse", 32'(o_commit_ack), 32'h1);
        chk("commit_value", 32'(o_switch_set), 32'h54321);
        chk("ready_in_ack_cycle", 32'(o_cfg_ready), 32'h1);
        chk("full_cleared", 32'(o_shadow_full), 32'h0);
        tick();
        chk("ack_one_cycle", 32'(o_commit_ack), 32'h0);

        // Early commit
        send_beat(4'h6); send_beat(4'h7); send_beat(4'h8);
        commit_pulse();
        chk("early_err", 32'(o_cfg_err), 32'h1);
        chk("early_no_ack", 32'(o_commit_ack), 32'h0);
        chk("early_switch_kept", 32'(o_switch_set), 32'h54321);
        chk("early_idx_kept", 32'(o_stage_idx), 32'h3);
        tick();
        chk("err_one_cycle", 32'(o_cfg_err), 32'h0);
        send_beat(4'h9); send_beat(4'hA);
        chk("full_after_resume", 32'(o_shadow_full), 32'h1);
        commit_pulse();
        chk("resume_value", 32'(o_switch_set), 32'hA9876);

        // Abort in LOAD drops the concurrent beat
        send_beat(4'h1); send_beat(4'h2);
        i_abort = 1'b1;
        send_beat(4'h3);
        i_abort = 1'b0;
        chk("abort_load_idx", 32'(o_stage_idx), 32'h0);
        chk("abort_load_ready", 32'(o_cfg_ready), 32'h1);

        // Abort and commit together in FULL
        send_beat(4'hB); send_beat(4'hC); send_beat(4'hD); send_beat(4'hE); send_beat(4'hF);
        chk("full_before_abort", 32'(o_shadow_full), 32'h1);
        i_abort = 1'b1;
        commit_pulse();
        i_abort = 1'b0;
        chk("abort_commit_no_ack_err", 32'({o_commit_ack, o_cfg_err}), 32'h0);
        chk("abort_commit_switch", 32'(o_switch_set), 32'hA9876);
        chk("abort_commit_idx", 32'(o_stage_idx), 32'h0);
        chk("abort_commit_state", 32'({o_cfg_ready, o_shadow_full}), 32'h2);
        for (int i = 0; i < 5; i++) send_beat(4'hF);
        commit_pulse();
        chk("all_cross", 32'(o_switch_set), 32'hFFFFF);

        // Gapped valid, commit on final beat, valid held in FULL
        send_beat(4'h3);
        tick(); tick();
        chk("gap_idx_hold", 32'(o_stage_idx), 32'h1);
        send_beat(4'hF);
        tick();
        send_beat(4'h5); send_beat(4'hA);
        tick(); tick(); tick();
        chk("gap_idx_4", 32'(o_stage_idx), 32'h4);
        i_commit    = 1'b1;
        i_cfg_valid = 1'b1;
        i_cfg_data  = 4'h0;
        tick();
        i_commit   = 1'b0;
        i_cfg_data = 4'h7;
        chk("last_beat_commit_err", 32'(o_cfg_err), 32'h1);
        chk("last_beat_still_full", 32'(o_shadow_full), 32'h1);
        tick(); tick(); tick(); tick();
        chk("held_valid_full", 32'({o_shadow_full, o_cfg_ready}), 32'h2);
        chk("held_valid_idx", 32'(o_stage_idx), 32'h0);
        chk("held_valid_switch", 32'(o_switch_set), 32'hFFFFF);
        i_commit = 1'b1;
        tick();
        i_commit    = 1'b0;
        i_cfg_valid = 1'b0;
        chk("gapped_value", 32'(o_switch_set), 32'h0A5F3);
        chk("gapped_ack", 32'(o_commit_ack), 32'h1);

        // Reset mid-load after a prior commit
        send_beat(4'h1); send_beat(4'h2); send_beat(4'h3); send_beat(4'h4); send_beat(4'h5);
        commit_pulse();
        chk("pre_reset_value", 32'(o_switch_set), 32'h54321);
        send_beat(4'h8); send_beat(4'h9);
        rst_n = 1'b0;
        tick();
        chk("midload_rst_switch", 32'(o_switch_set), 32'h0);
        chk("midload_rst_idx", 32'(o_stage_idx), 32'h0);
        chk("midload_rst_ready", 32'(o_cfg_ready), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("midload_release_ready", 32'(o_cfg_ready), 32'h1);
        send_beat(4'hC); send_beat(4'hD); send_beat(4'hE); send_beat(4'h1); send_beat(4'h2);
        commit_pulse();
        chk("post_reset_value", 32'(o_switch_set), 32'h21EDC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
